// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with an in-order prefetch queue and branch flush.
// Ports:
//   clk, reset            clock and synchronous active-low reset
//   pc_out / pc_write / pc_next        PC register interface
//   halt, redirect_valid, redirect_pc  fetch suppression and branch redirect
//   imem_req/addr/ready/rvalid/rdata   instruction-memory read interface
//   if_valid/if_instr/if_pc, id_ready  decode handshake for the queue head
//   perf_fetch_cnt, perf_bubble_cnt    saturating counters, only with FETCH_PERF_EN
module fetch_unit #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] pc_out,
   output logic        pc_write,
   output logic [15:0] pc_next,
   input  logic        halt,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [15:0] imem_rdata,
   output logic        if_valid,
   output logic [15:0] if_instr,
   output logic [15:0] if_pc,
   input  logic        id_ready
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0] perf_fetch_cnt,
   output logic [15:0] perf_bubble_cnt
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {EMPTY, PENDING, FULL} st_e;
   st_e           st_q    [DEPTH];
   logic [15:0]   pc_q    [DEPTH];
   logic [15:0]   instr_q [DEPTH];
   logic [AW-1:0] head_q, tail_q, fill_q;
   logic [CW-1:0] alloc_q, pend_q, drop_q, drop_sum;
   logic          accept, rsp_fill, consume;
   assign imem_addr = pc_out;
   assign imem_req  = reset & ~halt & ~redirect_valid & ((alloc_q + drop_q) < CW'(DEPTH));
   assign accept    = imem_req & imem_ready;
   // responses fill strictly in request order; fill_q tracks the oldest PENDING entry
   assign rsp_fill  = imem_rvalid & (drop_q == '0) & (pend_q != '0);
   assign consume   = if_valid & id_ready & ~redirect_valid;
   assign pc_write  = reset & (redirect_valid | accept);
   assign pc_next   = redirect_valid ? redirect_pc : accept ? pc_out + 16'd1 : pc_out;
   assign if_valid  = st_q[head_q] == FULL;
   assign if_instr  = instr_q[head_q];
   assign if_pc     = pc_q[head_q];
   // on a flush every PENDING entry turns into a response still owed by memory
   assign drop_sum  = drop_q + pend_q;
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            st_q[i]    <= EMPTY;
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         fill_q  <= '0;
         alloc_q <= '0;
         pend_q  <= '0;
         drop_q  <= '0;
      end else if (redirect_valid) begin
         for (int i = 0; i < DEPTH; i++) st_q[i] <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         fill_q  <= '0;
         alloc_q <= '0;
         pend_q  <= '0;
         // a response arriving in the flush cycle is itself discarded
         drop_q  <= drop_sum - CW'(imem_rvalid && drop_sum != '0);
      end else begin
         if (accept) begin
            st_q[tail_q] <= PENDING;
            pc_q[tail_q] <= pc_out;
            tail_q       <= tail_q + 1'b1;
         end
         if (imem_rvalid && drop_q != '0) drop_q <= drop_q - CW'(1);
         if (rsp_fill) begin
            st_q[fill_q]    <= FULL;
            instr_q[fill_q] <= imem_rdata;
            fill_q          <= fill_q + 1'b1;
         end
         if (consume) begin
            st_q[head_q] <= EMPTY;
            head_q       <= head_q + 1'b1;
         end
         alloc_q <= alloc_q + CW'(accept) - CW'(consume);
         pend_q  <= pend_q + CW'(accept) - CW'(rsp_fill);
      end
   end
`ifdef FETCH_PERF_EN
   logic [15:0] fetch_q, bubble_q;
   assign perf_fetch_cnt  = fetch_q;
   assign perf_bubble_cnt = bubble_q;
   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (consume && fetch_q != 16'hFFFF) fetch_q <= fetch_q + 16'd1;
         if (id_ready && !if_valid && bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed check of fetch_unit against a queue-based reference model.
module tb_fetch_unit;
   localparam int DEPTH = 2;
   logic        clk = 1'b0;
   logic        reset, halt, redirect_valid, imem_ready, imem_rvalid, id_ready;
   logic [15:0] pc_out, redirect_pc, imem_rdata;
   logic        pc_write, imem_req, if_valid;
   logic [15:0] pc_next, imem_addr, if_instr, if_pc;
`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetch_cnt, perf_bubble_cnt;
   int          pf = 0, pb = 0;
`endif
   fetch_unit #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .pc_out(pc_out), .pc_write(pc_write), .pc_next(pc_next),
      .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
`ifdef FETCH_PERF_EN
      , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [15:0] pc;
      logic [15:0] ins;
      bit          full;
   } ent_t;
   ent_t        eq[$];
   logic [15:0] mem_q[$];
   int          drop = 0;
   logic [15:0] pc = 16'h0000;
   bit          post_rst = 1'b0;
   int          checks = 0;
   int          failures = 0;
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step(input bit rn, input bit h, input bit rd, input logic [15:0] rpc,
                       input bit rdy, input bit idr, input int rv_pct);
      bit          v, acc, rv, exp_req, exp_pw;
      logic [15:0] epn, cur_pc, rdat;
      int          p, k;
      ent_t        t;
      @(negedge clk);
      rv   = rn && mem_q.size() > 0 && ($urandom_range(99) < rv_pct);
      rdat = rv ? (mem_q[0] ^ 16'h5A5A) : 16'($urandom);
      reset = rn; halt = h; redirect_valid = rd; redirect_pc = rpc;
      imem_ready = rdy; id_ready = idr; imem_rvalid = rv; imem_rdata = rdat; pc_out = pc;
      #1;
      exp_req = rn && !h && !rd && (eq.size() + drop < DEPTH);
      acc     = exp_req && rdy;
      exp_pw  = rn && (rd || acc);
      epn     = rd ? rpc : acc ? pc + 16'd1 : pc;
      v       = eq.size() > 0 && eq[0].full;
      chk("imem_req", 16'(imem_req), 16'(exp_req));
      chk("pc_write", 16'(pc_write), 16'(exp_pw));
      if (rn) chk("pc_next", pc_next, epn);
      chk("imem_addr", imem_addr, pc);
      chk("if_valid", 16'(if_valid), 16'(v));
      if (v) begin
         chk("if_pc", if_pc, eq[0].pc);
         chk("if_instr", if_instr, eq[0].ins);
      end
      if (post_rst) begin
         chk("rst_if_pc", if_pc, 16'h0000);
         chk("rst_if_instr", if_instr, 16'h0000);
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetch", perf_fetch_cnt, 16'(pf));
      chk("perf_bubble", perf_bubble_cnt, 16'(pb));
      if (!rn) begin pf = 0; pb = 0; end
      else begin
         if (!rd && v && idr && pf < 65535) pf++;
         if (idr && !v && pb < 65535) pb++;
      end
`endif
      cur_pc = pc;
      if (!rn) begin
         eq.delete();
         drop = 0;
      end else if (rd) begin
         p = 0;
         foreach (eq[i]) if (!eq[i].full) p++;
         drop = drop + p - ((rv && drop + p > 0) ? 1 : 0);
         eq.delete();
      end else begin
         if (rv) begin
            if (drop > 0) drop--;
            else begin
               k = -1;
               foreach (eq[i]) if (k < 0 && !eq[i].full) k = i;
               if (k >= 0) begin
                  t = eq[k]; t.full = 1'b1; t.ins = rdat; eq[k] = t;
               end
            end
         end
         if (v && idr) void'(eq.pop_front());
         if (acc) begin
            t.pc = cur_pc; t.ins = 16'h0; t.full = 1'b0;
            eq.push_back(t);
         end
      end
      @(posedge clk);
      if (!rn) mem_q.delete();
      else begin
         if (rv) void'(mem_q.pop_front());
         if (acc) mem_q.push_back(cur_pc);
      end
      if (exp_pw) pc = epn;
      post_rst = !rn;
   endtask
   initial begin
      reset = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0; pc_out = '0;
      repeat (2) step(0, 0, 0, 0, 1, 1, 0);
      // streaming from 0x0000 with one-cycle memory latency
      repeat (20) step(1, 0, 0, 0, 1, 1, 100);
      // back-pressure: queue fills and requests stop, one consume frees a slot
      repeat (6) step(1, 0, 0, 0, 1, 0, 100);
      step(1, 0, 0, 0, 1, 1, 100);
      repeat (3) step(1, 0, 0, 0, 1, 0, 100);
      // two reads in flight, then redirect to 0x0040
      step(0, 0, 0, 0, 1, 0, 0);
      repeat (2) step(1, 0, 0, 0, 1, 0, 0);
      step(1, 0, 1, 16'h0040, 1, 0, 0);
      repeat (10) step(1, 0, 0, 0, 1, 1, 100);
      // PC wrap at 0xFFFF
      step(1, 0, 1, 16'hFFFF, 1, 1, 100);
      repeat (8) step(1, 0, 0, 0, 1, 1, 100);
      // halt blocks requests while the queue still drains
      repeat (3) step(1, 0, 0, 0, 1, 0, 0);
      repeat (6) step(1, 1, 0, 0, 1, 1, 100);
      // reset in the middle of a stream
      repeat (4) step(1, 0, 0, 0, 1, 1, 60);
      step(0, 0, 0, 0, 1, 1, 60);
      repeat (4) step(1, 0, 0, 0, 1, 1, 60);
      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         bit rn, rd;
         logic [15:0] rpc;
         rn  = $urandom_range(199) != 0;
         rd  = rn && $urandom_range(99) < 8;
         rpc = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
         step(rn, $urandom_range(99) < 20, rd, rpc, $urandom_range(99) < 70,
              $urandom_range(99) < 60, 60);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage between the program counter and decode.
- Reads `pc_out`, issues word-addressed reads to instruction memory, and drives `pc_write`/`pc_next` back to the PC register.
- Buffers returned instructions with their PCs in a small in-order prefetch queue, presented to decode with a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding in-flight responses.

Parameters:
- DEPTH, 2, prefetch entries and max outstanding reads; power of two, 2..8.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset; asserted when 0, sampled on the rising edge of clk.
- pc_out  input  16  current PC from the program counter.
- pc_write  output  1  PC update enable (combinational).
- pc_next  output  16  next PC value (combinational).
- halt  input  1  suppress new fetch requests.
- redirect_valid  input  1  branch/jump taken; flush and load redirect_pc.
- redirect_pc  input  16  redirect target.
- imem_req  output  1  read request valid (combinational).
- imem_addr  output  16  read word address; equals pc_out.
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid; responses return in request order.
- imem_rdata  input  16  instruction word.
- if_valid  output  1  head entry holds an instruction (registered).
- if_instr  output  16  head instruction.
- if_pc  output  16  PC of the head instruction.
- id_ready  input  1  decode consumes the head when if_valid is also 1.

Behaviour:
- Reset (reset=0 at clk edge):
  - All entries empty; drop_cnt=0; head and tail pointers 0.
  - if_valid=0, if_instr=0, if_pc=0.
  - imem_req=0 and pc_write=0 while reset=0.
- Entry states are EMPTY, PENDING and FULL.
  - alloc_cnt is the number of PENDING plus FULL entries.
  - drop_cnt counts stale in-flight responses.
- Issue:
  - imem_req = reset & !halt & !redirect_valid & (alloc_cnt + drop_cnt < DEPTH).
  - On imem_req & imem_ready:
    - Tail entry becomes PENDING with pc=pc_out.
    - pc_write=1, pc_next=pc_out+1, modulo 2^16 (0xFFFF -> 0x0000).
    - At most one request per cycle.
- Response on imem_rvalid:
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Else the oldest PENDING entry becomes FULL with instr=imem_rdata.
  - Else (no PENDING entry): ignore the response.
  - imem_rvalid must be at least 1 cycle after acceptance.
  - A response and a new request in the same cycle are both handled.
- Output:
  - if_valid=1 when the head entry is FULL; if_instr/if_pc come from the head.
  - Minimum latency: response at edge N gives if_valid=1 after edge N.
  - On if_valid & id_ready the head entry becomes EMPTY and the head advances.
  - Consume, response and issue may all occur in one cycle.
- Redirect (redirect_valid=1):
  - Highest priority; pc_write=1, pc_next=redirect_pc.
  - No request is issued that cycle.
  - At the edge, all entries become EMPTY and the pointers reset to 0.
  - drop_cnt is loaded with drop_cnt + (PENDING count), minus 1 if imem_rvalid arrives that same cycle. That same-cycle response is discarded.
  - A same-cycle id_ready is ignored: no instruction is considered consumed.
  - if_valid=0 the cycle after.
- Halt:
  - Blocks new requests only.
  - Outstanding responses still fill entries, and decode still drains the queue.
- No request when pc_write=0; pc_next=pc_out when idle.
- Reset mid-operation clears drop_cnt. Memory shares the reset, so no pre-reset responses arrive; any stray rvalid is ignored as above.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, two outputs are added:
  - perf_fetch_cnt[15:0]: increments on each if_valid & id_ready.
  - perf_bubble_cnt[15:0]: increments on cycles with id_ready=1 and if_valid=0.
  - Both are 0 on reset and saturate at 0xFFFF.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Streaming: reset, pc_out starting 0x0000, imem_ready=1, rvalid 1 cycle later with rdata=0xA000+addr, id_ready=1 → decode sees pc 0x0000,0x0001,0x0002… with instr 0xA000,0xA001…; no gaps after fill.
- Back-pressure: DEPTH=2, id_ready=0 → exactly 2 requests accepted, then imem_req=0. One id_ready pulse → one entry freed, and imem_req=1 the next cycle.
- Redirect with 2 in flight: redirect_pc=0x0040 → pc_next=0x0040, drop_cnt=2, the next 2 rdata discarded, and the first if_pc after them is 0x0040.
- Wrap: pc_out=0xFFFF accepted → pc_next=0x0000, and the entry has if_pc=0xFFFF.
- Halt and reset: halt=1 gives imem_req=0 while queued instrs still drain. Driving reset=0 mid-stream → next cycle if_valid=0, drop_cnt=0, pc_write=0.
- FETCH_PERF_EN: 5 consumes plus 3 empty id_ready cycles → perf_fetch_cnt=5, perf_bubble_cnt=3. Saturation holds at 0xFFFF.
